// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART TX path among NUM_REQ byte sources.
// Optional launch-to-done watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CLKS     = 0,
  parameter int TIMEOUT_CLKS = 4096,
  localparam int OW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Grant,
  output logic [NUM_REQ-1:0]   o_Req_Done,
  output logic                 o_Tx_Ready,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy,
  output logic [OW-1:0]        o_Owner,
  output logic                 o_Timeout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] SEND   = 2'd2;
  localparam logic [1:0] GAP    = 2'd3;

  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  logic [1:0]    state;
  logic [OW-1:0] rr_ptr;
  logic [GW-1:0] gap_cnt;
  logic          found;
  logic [OW-1:0] win;
  logic [OW:0]   idx;
  logic [OW-1:0] nxt_ptr;
  logic [7:0]    sel_byte;
  logic          in_frame;
  logic          wd_fire;
  logic          fin;

  // first valid requester at or above rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (OW+1)'(k);
      if (idx >= (OW+1)'(NUM_REQ))
        idx = idx - (OW+1)'(NUM_REQ);
      if (!found && i_Req_Valid[idx[OW-1:0]]) begin
        found = 1'b1;
        win   = idx[OW-1:0];
      end
    end
  end

  assign sel_byte = i_Req_Byte[{win, 3'b000} +: 8];
  assign nxt_ptr  = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  assign in_frame = (state == LAUNCH) || (state == SEND);
  assign fin      = in_frame && (i_Tx_Done || wd_fire);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CLKS + 1);
  logic [WW-1:0] wd_cnt;

  assign wd_fire = in_frame && !i_Tx_Done &&
                   (int'(wd_cnt) >= TIMEOUT_CLKS - 1);

  // watchdog: cleared while idle, counts through LAUNCH/SEND
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt    <= '0;
      o_Timeout <= 1'b0;
    end else begin
      o_Timeout <= wd_fire;
      if (state == IDLE)
        wd_cnt <= '0;
      else if (in_frame)
        wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_fire   = 1'b0;
  assign o_Timeout = 1'b0;
`endif

  // arbitration, launch handshake, completion and gap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gap_cnt     <= '0;
      o_Req_Grant <= '0;
      o_Req_Done  <= '0;
      o_Tx_Ready  <= 1'b0;
      o_Tx_Byte   <= 8'h00;
      o_Busy      <= 1'b0;
      o_Owner     <= '0;
    end else begin
      o_Req_Grant <= '0;
      o_Req_Done  <= '0;
      case (state)
        IDLE: begin
          if (found && !i_Tx_Active) begin
            o_Req_Grant[win] <= 1'b1;
            o_Tx_Byte        <= sel_byte;
            o_Tx_Ready       <= 1'b1;
            o_Owner          <= win;
            rr_ptr           <= nxt_ptr;
            o_Busy           <= 1'b1;
            state            <= LAUNCH;
          end
        end
        LAUNCH, SEND: begin
          if (fin) begin
            if (i_Tx_Done)
              o_Req_Done[o_Owner] <= 1'b1;
            o_Tx_Ready <= 1'b0;
            gap_cnt    <= '0;
            if (GAP_CLKS == 0) begin
              o_Busy <= 1'b0;
              state  <= IDLE;
            end else begin
              state  <= GAP;
            end
          end else if (state == LAUNCH && i_Tx_Active) begin
            o_Tx_Ready <= 1'b0;
            state      <= SEND;
          end
        end
        GAP: begin
          if (int'(gap_cnt) >= GAP_CLKS - 1) begin
            gap_cnt <= '0;
            o_Busy  <= 1'b0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a behavioural UART TX stub.
// Timeout scenario built only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int GAP   = 10;
  localparam int TO    = 100;
  localparam int FRAME = 30;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_byte = '0;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        tx_ready;
  logic [7:0]  tx_byte;
  logic        busy;
  logic [1:0]  owner;
  logic        tmo;
  logic        tx_active;

  logic m_active = 1'b0;
  logic m_done = 1'b0;
  logic m_stall = 1'b0;
  logic foreign = 1'b0;
  int   m_cnt = 0;

  int n_tests = 0;
  int n_fail = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [3:0] seen_grant = '0;
  logic [3:0] seen_done = '0;

  assign tx_active = m_active | foreign;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_Req_Valid(req_valid), .i_Req_Byte(req_byte),
    .o_Req_Grant(grant), .o_Req_Done(done),
    .o_Tx_Ready(tx_ready), .o_Tx_Byte(tx_byte),
    .i_Tx_Active(tx_active), .i_Tx_Done(m_done),
    .o_Busy(busy), .o_Owner(owner), .o_Timeout(tmo)
  );

  always #5 clk = ~clk;

  // UART stub: latches the byte on ready, FRAME clocks active, done pulse
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (!m_active) begin
      if (tx_ready) begin
        m_active <= 1'b1;
        m_cnt    <= FRAME;
        rx_q.push_back(tx_byte);
      end
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (!m_stall) begin
      m_active <= 1'b0;
      m_done   <= 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
    seen_grant = seen_grant | grant;
    seen_done  = seen_done | done;
  endtask

  task automatic wait_grant(input int lim, output int cyc,
                            output logic [3:0] g);
    cyc = 0;
    g = '0;
    while (cyc < lim && g == 4'b0) begin
      tick();
      cyc++;
      g = grant;
    end
  endtask

  task automatic wait_done(input int lim, output logic [3:0] d);
    int c = 0;
    d = '0;
    while (c < lim && d == 4'b0) begin
      tick();
      c++;
      d = done;
    end
  endtask

  task automatic wait_tx_done(input int lim, output logic ok);
    int c = 0;
    ok = 1'b0;
    while (c < lim && !ok) begin
      tick();
      c++;
      ok = m_done;
    end
  endtask

  task automatic wait_send(input int lim, output logic ok);
    int c = 0;
    ok = 1'b0;
    while (c < lim && !ok) begin
      tick();
      c++;
      ok = m_active && !tx_ready && busy;
    end
  endtask

  task automatic wait_idle(input int lim, output logic ok);
    int c = 0;
    ok = !busy;
    while (c < lim && !ok) begin
      tick();
      c++;
      ok = !busy;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [20:0] v;
    tick();
    v = {grant, done, tx_ready, tx_byte, busy, owner, tmo};
    n_tests++;
    if (v !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_vals: got %h want 0", v);
    end
    reset_n = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (busy !== 1'b0 || grant !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy %b grant %b want 0", busy, grant);
    end
  endtask

  task automatic test_single();
    logic ok;
    logic [7:0] got, want;
    req_byte[23:16] = 8'hA5;
    req_valid = 4'b0100;
    exp_q.push_back(8'hA5);
    tick();
    n_tests++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_grant: got %b want 0100", grant);
    end
    n_tests++;
    if (tx_byte !== 8'hA5 || tx_ready !== 1'b1 || owner !== 2'd2) begin
      n_fail++;
      $display("FAIL single_launch: byte %h rdy %b own %0d want a5 1 2",
               tx_byte, tx_ready, owner);
    end
    req_valid = 4'b0;
    req_byte[23:16] = 8'h00;
    wait_tx_done(FRAME + 20, ok);
    tick();
    n_tests++;
    if (!ok || done !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_done: txdone %b got %b want 0100", ok, done);
    end
    got = 8'hxx;
    if (rx_q.size() > 0) got = rx_q.pop_front();
    want = exp_q.pop_front();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL single_loop: got %h want %h", got, want);
    end
    wait_idle(GAP + 5, ok);
  endtask

  task automatic test_round_robin();
    logic [7:0] rb [4] = '{8'h01, 8'h10, 8'h22, 8'h32};
    logic [3:0] g, d, w;
    logic [7:0] got, want;
    logic ok;
    int cyc;
    do_reset();
    req_byte = {rb[3], rb[2], rb[1], rb[0]};
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(rb[i % 4]);
      w = 4'b0001 << (i % 4);
      wait_grant(FRAME + GAP + 20, cyc, g);
      if (i == 4) req_valid = 4'b0;
      n_tests++;
      if (g !== w || (i > 0 && cyc != GAP + 1)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %b after %0d want %b", i, g, cyc, w);
      end
      wait_done(FRAME + 20, d);
      n_tests++;
      if (d !== w) begin
        n_fail++;
        $display("FAIL rr_done%0d: got %b want %b", i, d, w);
      end
      got = 8'hxx;
      if (rx_q.size() > 0) got = rx_q.pop_front();
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL rr_loop%0d: got %h want %h", i, got, want);
      end
    end
    wait_idle(GAP + 5, ok);
  endtask

  task automatic test_withdraw_simul();
    logic [3:0] g, d;
    logic [7:0] got, want;
    logic ok;
    int cyc;
    do_reset();
    req_byte = {8'h3C, 8'h00, 8'h66, 8'h5A};
    req_valid = 4'b0011;
    exp_q.push_back(8'h5A);
    wait_grant(10, cyc, g);
    req_valid[0] = 1'b0;
    n_tests++;
    if (g !== 4'b0001) begin
      n_fail++;
      $display("FAIL wd_grant0: got %b want 0001", g);
    end
    wait_send(10, ok);
    req_valid[1] = 1'b0;
    seen_grant = '0;
    wait_tx_done(FRAME + 20, ok);
    req_valid[3] = 1'b1;
    exp_q.push_back(8'h3C);
    tick();
    n_tests++;
    if (done !== 4'b0001) begin
      n_fail++;
      $display("FAIL wd_done0: got %b want 0001", done);
    end
    got = 8'hxx;
    if (rx_q.size() > 0) got = rx_q.pop_front();
    want = exp_q.pop_front();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL wd_loop0: got %h want %h", got, want);
    end
    wait_grant(GAP + 20, cyc, g);
    req_valid = 4'b0;
    n_tests++;
    if (g !== 4'b1000 || cyc != GAP + 1) begin
      n_fail++;
      $display("FAIL simul_grant: got %b after %0d want 1000 after %0d",
               g, cyc, GAP + 1);
    end
    n_tests++;
    if (seen_grant[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw: grants seen %b want none to 1", seen_grant);
    end
    wait_done(FRAME + 20, d);
    n_tests++;
    if (d !== 4'b1000) begin
      n_fail++;
      $display("FAIL simul_done: got %b want 1000", d);
    end
    got = 8'hxx;
    if (rx_q.size() > 0) got = rx_q.pop_front();
    want = exp_q.pop_front();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL simul_loop: got %h want %h", got, want);
    end
    wait_idle(GAP + 5, ok);
  endtask

  task automatic test_foreign();
    logic [3:0] g, d;
    logic [7:0] got, want;
    logic ok;
    int cyc;
    foreign = 1'b1;
    req_byte[7:0] = 8'hC3;
    req_valid = 4'b0001;
    exp_q.push_back(8'hC3);
    seen_grant = '0;
    repeat (20) tick();
    n_tests++;
    if (seen_grant !== 4'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL foreign_block: grants %b busy %b want 0 0",
               seen_grant, busy);
    end
    foreign = 1'b0;
    wait_grant(10, cyc, g);
    req_valid = 4'b0;
    n_tests++;
    if (g !== 4'b0001 || cyc != 1) begin
      n_fail++;
      $display("FAIL foreign_release: got %b after %0d want 0001 after 1",
               g, cyc);
    end
    wait_done(FRAME + 20, d);
    n_tests++;
    if (d !== 4'b0001) begin
      n_fail++;
      $display("FAIL foreign_done: got %b want 0001", d);
    end
    got = 8'hxx;
    if (rx_q.size() > 0) got = rx_q.pop_front();
    want = exp_q.pop_front();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL foreign_loop: got %h want %h", got, want);
    end
    wait_idle(GAP + 5, ok);
  endtask

  task automatic test_reset_midframe();
    logic [3:0] g, d;
    logic [7:0] got, want;
    logic [20:0] v;
    logic ok;
    int cyc;
    req_byte = {8'h44, 8'h99, 8'h22, 8'h11};
    req_valid = 4'b0100;
    exp_q.push_back(8'h99);
    wait_grant(10, cyc, g);
    req_valid = 4'b0;
    n_tests++;
    if (g !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_grant: got %b want 0100", g);
    end
    wait_send(10, ok);
    reset_n = 1'b0;
    #1;
    v = {grant, done, tx_ready, tx_byte, busy, owner, tmo};
    n_tests++;
    if (!ok || v !== 21'd0) begin
      n_fail++;
      $display("FAIL mid_reset_vals: send %b got %h want 0", ok, v);
    end
    tick();
    reset_n = 1'b1;
    seen_done = '0;
    got = 8'hxx;
    if (rx_q.size() > 0) got = rx_q.pop_front();
    want = exp_q.pop_front();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL mid_loop: got %h want %h", got, want);
    end
    req_valid = 4'hF;
    exp_q.push_back(8'h11);
    wait_grant(FRAME + 20, cyc, g);
    req_valid = 4'b0;
    n_tests++;
    if (g !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_next_grant: got %b want 0001", g);
    end
    n_tests++;
    if (seen_done !== 4'b0) begin
      n_fail++;
      $display("FAIL mid_no_done: got %b want 0000", seen_done);
    end
    wait_done(FRAME + 20, d);
    n_tests++;
    if (d !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_done: got %b want 0001", d);
    end
    got = 8'hxx;
    if (rx_q.size() > 0) got = rx_q.pop_front();
    want = exp_q.pop_front();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL mid_loop2: got %h want %h", got, want);
    end
    wait_idle(GAP + 5, ok);
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] g;
    logic [7:0] got, want;
    logic ok;
    int cyc;
    m_stall = 1'b1;
    req_byte[15:8] = 8'h77;
    req_valid = 4'b0010;
    exp_q.push_back(8'h77);
    wait_grant(10, cyc, g);
    req_valid = 4'b0;
    n_tests++;
    if (g !== 4'b0010) begin
      n_fail++;
      $display("FAIL to_grant: got %b want 0010", g);
    end
    seen_done = '0;
    cyc = 0;
    ok = 1'b0;
    while (cyc < 3 * TO && !ok) begin
      tick();
      cyc++;
      ok = tmo;
    end
    n_tests++;
    if (!ok || cyc != TO) begin
      n_fail++;
      $display("FAIL to_pulse: seen %b after %0d want 1 after %0d",
               ok, cyc, TO);
    end
    wait_idle(GAP + 5, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL to_idle: busy %b want 0", busy);
    end
    m_stall = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (seen_done !== 4'b0) begin
      n_fail++;
      $display("FAIL to_no_done: got %b want 0000", seen_done);
    end
    got = 8'hxx;
    if (rx_q.size() > 0) got = rx_q.pop_front();
    want = exp_q.pop_front();
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL to_loop: got %h want %h", got, want);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_withdraw_simul();
    test_foreign();
    test_reset_midframe();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
